// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Funct3 encodings, FSM state type and the latched request record.
package dmem_pkg;

   localparam int unsigned DMEM_DATA_W = 32;
   localparam int unsigned LANES       = DMEM_DATA_W / 8;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StAccess,
      StResp
   } dmem_state_t;

   typedef struct packed {
      logic                   we;
      logic [2:0]             funct3;
      logic [DMEM_DATA_W-1:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane steering: store byte enables / lane data,
// load extraction with sign/zero extension, and alignment/funct3 errors.
import dmem_pkg::*;

module dmem_lane_fmt (
   input  logic [2:0]             i_funct3,
   input  logic [1:0]             i_lane,
   input  logic [DMEM_DATA_W-1:0] i_raw,
   input  logic [DMEM_DATA_W-1:0] i_wdata,
   output logic [LANES-1:0]       o_be,
   output logic [DMEM_DATA_W-1:0] o_wdata_lane,
   output logic [DMEM_DATA_W-1:0] o_rdata,
   output logic                   o_err
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_raw[{i_lane, 3'b000} +: 8];
   assign w_half = i_lane[1] ? i_raw[31:16] : i_raw[15:0];

   // funct3[2] only selects zero extension on loads; stores use the size bits alone.
   always_comb begin
      o_be         = '0;
      o_wdata_lane = '0;
      o_rdata      = '0;
      o_err        = 1'b0;
      unique case (i_funct3)
         F3_B, F3_BU: begin
            o_be         = 4'b0001 << i_lane;
            o_wdata_lane = {4{i_wdata[7:0]}};
            o_rdata      = i_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         F3_H, F3_HU: begin
            if (i_lane[0]) begin
               o_err = 1'b1;
            end else begin
               o_be         = i_lane[1] ? 4'b1100 : 4'b0011;
               o_wdata_lane = {2{i_wdata[15:0]}};
               o_rdata      = i_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            end
         end
         F3_W: begin
            if (i_lane != 2'b00) begin
               o_err = 1'b1;
            end else begin
               o_be         = 4'b1111;
               o_wdata_lane = i_wdata;
               o_rdata      = i_raw;
            end
         end
         default: o_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// held response. Optional counters when DMEM_STATS_EN is defined.
import dmem_pkg::*;

module dmem_responder #(
   parameter int unsigned DM_ADDRESS  = 9,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [2:0]            req_funct3,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0]           stat_loads,
   output logic [15:0]           stat_stores,
   output logic [15:0]           stat_errs
`endif
);

   localparam int unsigned DEPTH     = 1 << (DM_ADDRESS - 2);
   localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES - 1);

   dmem_state_t             r_state;
   dmem_state_t             w_state_d;
   logic [3:0]              r_wait_cnt;
   dmem_req_t               r_req;
   logic [DM_ADDRESS-1:0]   r_addr;
   logic                    r_rsp_valid;
   logic                    r_rsp_err;
   logic [DATA_W-1:0]       r_rsp_rdata;
   logic [DATA_W-1:0]       r_mem [DEPTH];

   logic                    w_accept;
   logic                    w_rsp_hs;
   logic [DM_ADDRESS-3:0]   w_idx;
   logic [DATA_W-1:0]       w_raw;
   logic [LANES-1:0]        w_be;
   logic [DATA_W-1:0]       w_wdata_lane;
   logic [DATA_W-1:0]       w_rdata_fmt;
   logic                    w_err;

   assign req_ready = (r_state == StIdle);
   assign w_accept  = req_valid && req_ready;
   assign w_rsp_hs  = r_rsp_valid && rsp_ready;
   assign w_idx     = r_addr[DM_ADDRESS-1:2];
   assign w_raw     = r_mem[w_idx];

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

   dmem_lane_fmt u_lane_fmt (
      .i_funct3     (r_req.funct3),
      .i_lane       (r_addr[1:0]),
      .i_raw        (w_raw),
      .i_wdata      (r_req.wdata),
      .o_be         (w_be),
      .o_wdata_lane (w_wdata_lane),
      .o_rdata      (w_rdata_fmt),
      .o_err        (w_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_state_d = (WAIT_STATES > 0) ? StWait : StAccess;
            end
         end
         StWait: begin
            if (r_wait_cnt == WAIT_LAST) begin
               w_state_d = StAccess;
            end
         end
         StAccess: w_state_d = StResp;
         StResp: begin
            if (w_rsp_hs) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (r_state == StWait && r_wait_cnt != WAIT_LAST) begin
         r_wait_cnt <= r_wait_cnt + 4'd1;
      end else begin
         r_wait_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req  <= '0;
         r_addr <= '0;
      end else if (w_accept) begin
         r_req  <= '{we: req_we, funct3: req_funct3, wdata: req_wdata};
         r_addr <= req_addr;
      end
   end

   // Formatter already zeroes load data on error; stores always return zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else if (r_state == StAccess) begin
         r_rsp_valid <= 1'b1;
         r_rsp_rdata <= r_req.we ? '0 : w_rdata_fmt;
         r_rsp_err   <= w_err;
      end else if (w_rsp_hs) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == StAccess && r_req.we && !w_err) begin
         for (int i = 0; i < LANES; i++) begin
            if (w_be[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_wdata_lane[8*i +: 8];
            end
         end
      end
   end

`ifdef DMEM_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_errs   <= '0;
      end else if (w_rsp_hs) begin
         if (r_rsp_err) begin
            if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
         end else if (r_req.we) begin
            if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
         end else begin
            if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder (WAIT_STATES = 1),
// plus hand sequences for back-pressure and reset during a wait state.
module tb_dmem_responder;

   localparam int unsigned WS = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [8:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef DMEM_STATS_EN
   logic [15:0] stat_loads;
   logic [15:0] stat_stores;
   logic [15:0] stat_errs;
`endif

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   dmem_responder #(
      .DM_ADDRESS  (9),
      .DATA_W      (32),
      .WAIT_STATES (WS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
`ifdef DMEM_STATS_EN
      ,
      .stat_loads  (stat_loads),
      .stat_stores (stat_stores),
      .stat_errs   (stat_errs)
`endif
   );

   typedef struct {
      string       name;
      logic        we;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic send_req(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                           input logic [2:0] f3);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wd;
      req_funct3 = f3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Cycles counted from the accept edge; 33 means the response never came.
   task automatic wait_rsp(output int n);
      n = 0;
      while (n < 32) begin
         @(negedge clk);
         n++;
         if (rsp_valid) return;
      end
      n = 33;
   endtask

   task automatic ack();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      send_req(v.we, v.addr, v.wdata, v.f3);
      wait_rsp(n);
      check({v.name, " latency"}, 32'(n), 32'(WS + 2));
      check({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
      check({v.name, " err"}, 32'(rsp_err), 32'(v.exp_err));
      ack();
   endtask

   function automatic vec_t mk(input string name, input logic we, input logic [8:0] addr,
                               input logic [31:0] wd, input logic [2:0] f3,
                               input logic [31:0] er, input logic ee);
      vec_t v;
      v.name = name; v.we = we; v.addr = addr; v.wdata = wd; v.f3 = f3;
      v.exp_rdata = er; v.exp_err = ee;
      return v;
   endfunction

   initial begin
      int n;

      vecs.push_back(mk("sw_010",     1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0,        0));
      vecs.push_back(mk("lw_010_a",   0, 9'h010, 32'h0,        3'b010, 32'hDEADBEEF, 0));
      vecs.push_back(mk("sb_012",     1, 9'h012, 32'h000000A5, 3'b000, 32'h0,        0));
      vecs.push_back(mk("lw_010_b",   0, 9'h010, 32'h0,        3'b010, 32'hDEA5BEEF, 0));
      vecs.push_back(mk("lb_012",     0, 9'h012, 32'h0,        3'b000, 32'hFFFFFFA5, 0));
      vecs.push_back(mk("lbu_012",    0, 9'h012, 32'h0,        3'b100, 32'h000000A5, 0));
      vecs.push_back(mk("sh_010",     1, 9'h010, 32'h00008001, 3'b001, 32'h0,        0));
      vecs.push_back(mk("lh_010",     0, 9'h010, 32'h0,        3'b001, 32'hFFFF8001, 0));
      vecs.push_back(mk("lhu_010",    0, 9'h010, 32'h0,        3'b101, 32'h00008001, 0));
      vecs.push_back(mk("lw_013_mis", 0, 9'h013, 32'h0,        3'b010, 32'h0,        1));
      vecs.push_back(mk("sh_011_mis", 1, 9'h011, 32'h00001234, 3'b001, 32'h0,        1));
      vecs.push_back(mk("lw_010_c",   0, 9'h010, 32'h0,        3'b010, 32'hDEA58001, 0));
      vecs.push_back(mk("ld_f3_011",  0, 9'h010, 32'h0,        3'b011, 32'h0,        1));
      vecs.push_back(mk("ld_f3_110",  0, 9'h010, 32'h0,        3'b110, 32'h0,        1));
      vecs.push_back(mk("lh_012",     0, 9'h012, 32'h0,        3'b001, 32'hFFFFDEA5, 0));
      vecs.push_back(mk("lb_013",     0, 9'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 0));
      vecs.push_back(mk("lbu_011",    0, 9'h011, 32'h0,        3'b100, 32'h00000080, 0));
      vecs.push_back(mk("sw_014",     1, 9'h014, 32'h11223344, 3'b010, 32'h0,        0));
      vecs.push_back(mk("sb_017",     1, 9'h017, 32'hFFFFFF7C, 3'b000, 32'h0,        0));
      vecs.push_back(mk("lw_014_a",   0, 9'h014, 32'h0,        3'b010, 32'h7C223344, 0));
      vecs.push_back(mk("sh_016",     1, 9'h016, 32'h0000ABCD, 3'b001, 32'h0,        0));
      vecs.push_back(mk("lw_014_b",   0, 9'h014, 32'h0,        3'b010, 32'hABCD3344, 0));
      vecs.push_back(mk("st_f3_011",  1, 9'h014, 32'h0,        3'b011, 32'h0,        1));
      vecs.push_back(mk("sw_016_mis", 1, 9'h016, 32'h0,        3'b010, 32'h0,        1));
      vecs.push_back(mk("lw_014_c",   0, 9'h014, 32'h0,        3'b010, 32'hABCD3344, 0));

      // Reset state
      repeat (2) @(negedge clk);
      check("rst req_ready", 32'(req_ready), 32'h1);
      check("rst rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst rsp_rdata", rsp_rdata, 32'h0);
      check("rst rsp_err", 32'(rsp_err), 32'h0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Back-pressure: response held, a request pulse during RESP is ignored
      send_req(1'b0, 9'h010, 32'h0, 3'b010);
      wait_rsp(n);
      check("bp latency", 32'(n), 32'(WS + 2));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 1) begin
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_addr   = 9'h010;
            req_wdata  = 32'h0;
            req_funct3 = 3'b010;
         end else begin
            req_valid = 1'b0;
         end
         check("bp rsp_valid", 32'(rsp_valid), 32'h1);
         check("bp rsp_rdata", rsp_rdata, 32'hDEA58001);
         check("bp req_ready", 32'(req_ready), 32'h0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      ack();
      check("post_hs rsp_valid", 32'(rsp_valid), 32'h0);
      check("post_hs req_ready", 32'(req_ready), 32'h1);
      run_vec(mk("lw_010_after_bp", 0, 9'h010, 32'h0, 3'b010, 32'hDEA58001, 0));

      // Reset while a store sits in WAIT
      run_vec(mk("sw_020", 1, 9'h020, 32'h55AA55AA, 3'b010, 32'h0, 0));
      send_req(1'b1, 9'h020, 32'h12345678, 3'b010);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst rsp_valid", 32'(rsp_valid), 32'h0);
      check("midrst req_ready", 32'(req_ready), 32'h1);
`ifdef DMEM_STATS_EN
      check("midrst stat_loads", 32'(stat_loads), 32'h0);
      check("midrst stat_stores", 32'(stat_stores), 32'h0);
      check("midrst stat_errs", 32'(stat_errs), 32'h0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_vec(mk("lw_020_after_rst", 0, 9'h020, 32'h0, 3'b010, 32'h55AA55AA, 0));
`ifdef DMEM_STATS_EN
      check("post_rst stat_loads", 32'(stat_loads), 32'h1);
      check("post_rst stat_stores", 32'(stat_stores), 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
